// File: rtl/imm_instr_encoder.sv
// Instruction encoder and instruction-memory loader.
// Scatters a signed immediate into I/S/B/J layout and writes the word out.
module imm_instr_encoder #(
    parameter int ADDR_W    = 8,
    parameter int BASE_ADDR = 0
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              start,
    input  logic              clr_err,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [1:0]        fmt,
    input  logic [6:0]        opcode,
    input  logic [4:0]        rd,
    input  logic [4:0]        rs1,
    input  logic [4:0]        rs2,
    input  logic [2:0]        funct3,
    input  logic [31:0]       imm,
    output logic              im_we,
    output logic [ADDR_W-1:0] im_addr,
    output logic [31:0]       im_wdata,
    output logic              err,
    output logic [1:0]        err_code,
    output logic              full,
    output logic [ADDR_W:0]   count
);

    typedef enum logic [1:0] {IDLE, ENC, WR, ERR} state_t;

    localparam logic [ADDR_W-1:0] BASE = ADDR_W'(BASE_ADDR);

    state_t      state, state_nx;
    logic [1:0]  fmt_q;
    logic [6:0]  op_q;
    logic [4:0]  rd_q, rs1_q, rs2_q;
    logic [2:0]  f3_q;
    logic [31:0] imm_q;
    logic [31:0] enc;
    logic [1:0]  chk;
    logic        accept;
    logic        bad_is, bad_b, bad_j;

    assign in_ready = (state == IDLE) && !start;
    assign accept   = in_valid && in_ready;
    assign im_we    = (state == WR);
    assign err      = (state == ERR);

    always_comb begin
        enc = '0;
        unique case (fmt_q)
            2'd0: enc = {imm_q[11:0], rs1_q, f3_q, rd_q, op_q};
            2'd1: enc = {imm_q[11:5], rs2_q, rs1_q, f3_q,
                         imm_q[4:0], op_q};
            2'd2: enc = {imm_q[12], imm_q[10:5], rs2_q, rs1_q, f3_q,
                         imm_q[4:1], imm_q[11], op_q};
            2'd3: enc = {imm_q[20], imm_q[10:1], imm_q[11],
                         imm_q[19:12], rd_q, op_q};
        endcase
    end

    // Legal iff the bits above the field's sign bit replicate it.
    assign bad_is = !((&imm_q[31:11]) || !(|imm_q[31:11]));
    assign bad_b  = !((&imm_q[31:12]) || !(|imm_q[31:12]));
    assign bad_j  = !((&imm_q[31:20]) || !(|imm_q[31:20]));

    always_comb begin
        chk = 2'd0;
        if (full)
            chk = 2'd3;
        else if (fmt_q[1] && imm_q[0])
            chk = 2'd2;
        else if ((!fmt_q[1] && bad_is) ||
                 (fmt_q == 2'd2 && bad_b) ||
                 (fmt_q == 2'd3 && bad_j))
            chk = 2'd1;
    end

    always_comb begin
        state_nx = state;
        unique case (state)
            IDLE: if (accept) state_nx = ENC;
            ENC:  state_nx = (chk == 2'd0) ? WR : ERR;
            WR:   state_nx = IDLE;
            ERR:  if (clr_err) state_nx = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            state <= IDLE;
        else
            state <= state_nx;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            fmt_q    <= '0;
            op_q     <= '0;
            rd_q     <= '0;
            rs1_q    <= '0;
            rs2_q    <= '0;
            f3_q     <= '0;
            imm_q    <= '0;
            im_wdata <= '0;
            im_addr  <= BASE;
            err_code <= '0;
            full     <= 1'b0;
            count    <= '0;
        end else begin
            unique case (state)
                IDLE: begin
                    if (start) begin
                        im_addr <= BASE;
                        full    <= 1'b0;
                        count   <= '0;
                    end else if (accept) begin
                        fmt_q <= fmt;
                        op_q  <= opcode;
                        rd_q  <= rd;
                        rs1_q <= rs1;
                        rs2_q <= rs2;
                        f3_q  <= funct3;
                        imm_q <= imm;
                    end
                end
                ENC: begin
                    if (chk == 2'd0)
                        im_wdata <= enc;
                    else
                        err_code <= chk;
                end
                WR: begin
                    count <= count + 1'b1;
                    // Saturate at the top word; the counter never wraps.
                    if (&im_addr)
                        full <= 1'b1;
                    else
                        im_addr <= im_addr + 1'b1;
                end
                ERR: begin
                    if (clr_err)
                        err_code <= '0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_imm_instr_encoder.sv
// Testbench for imm_instr_encoder (small address space to reach full).
// Writes are scoreboarded: expectations queued on request, popped on im_we.
module tb_imm_instr_encoder;

    localparam int AW = 2;

    typedef struct {
        logic [AW-1:0] addr;
        logic [31:0]   data;
        logic          exact;
        logic [1:0]    fmt;
        logic [31:0]   imm;
        logic [6:0]    op;
    } exp_t;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          start = 1'b0;
    logic          clr_err = 1'b0;
    logic          in_valid = 1'b0;
    logic          in_ready;
    logic [1:0]    fmt = '0;
    logic [6:0]    opcode = '0;
    logic [4:0]    rd = '0;
    logic [4:0]    rs1 = '0;
    logic [4:0]    rs2 = '0;
    logic [2:0]    funct3 = '0;
    logic [31:0]   imm = '0;
    logic          im_we;
    logic [AW-1:0] im_addr;
    logic [31:0]   im_wdata;
    logic          err;
    logic [1:0]    err_code;
    logic          full;
    logic [AW:0]   count;

    int checks = 0;
    int errors = 0;

    exp_t sb[$];

    logic [AW-1:0] m_addr = '0;
    logic          m_full = 1'b0;
    logic [AW:0]   m_count = '0;

    imm_instr_encoder #(.ADDR_W(AW), .BASE_ADDR(0)) dut (
        .clk(clk), .rst_n(rst_n), .start(start), .clr_err(clr_err),
        .in_valid(in_valid), .in_ready(in_ready), .fmt(fmt),
        .opcode(opcode), .rd(rd), .rs1(rs1), .rs2(rs2),
        .funct3(funct3), .imm(imm), .im_we(im_we), .im_addr(im_addr),
        .im_wdata(im_wdata), .err(err), .err_code(err_code),
        .full(full), .count(count)
    );

    always #5 clk = ~clk;

    initial begin
        #300000;
        $display("FAIL watchdog timeout");
        $fatal(1, "watchdog");
    end

    function automatic logic [31:0] dec(input logic [1:0] f,
                                        input logic [31:0] w);
        logic [31:0] r;
        case (f)
            2'd0: r = {{20{w[31]}}, w[31:20]};
            2'd1: r = {{20{w[31]}}, w[31:25], w[11:7]};
            2'd2: r = {{19{w[31]}}, w[31], w[7], w[30:25], w[11:8], 1'b0};
            default: r = {{11{w[31]}}, w[31], w[19:12], w[20],
                          w[30:21], 1'b0};
        endcase
        return r;
    endfunction

    // Write monitor / scoreboard consumer
    always @(negedge clk) begin
        if (im_we) begin
            checks++;
            if (sb.size() == 0) begin
                errors++;
                $display("FAIL unexpected_write addr %h data %h",
                         im_addr, im_wdata);
            end else begin
                exp_t e;
                e = sb.pop_front();
                if (im_addr !== e.addr) begin
                    errors++;
                    $display("FAIL wr_addr got %h want %h",
                             im_addr, e.addr);
                end
                if (e.exact) begin
                    checks++;
                    if (im_wdata !== e.data) begin
                        errors++;
                        $display("FAIL wr_data got %h want %h",
                                 im_wdata, e.data);
                    end
                end else begin
                    checks++;
                    if (dec(e.fmt, im_wdata) !== e.imm ||
                        im_wdata[6:0] !== e.op) begin
                        errors++;
                        $display("FAIL wr_decode fmt %0d word %h got %h want %h",
                                 e.fmt, im_wdata, dec(e.fmt, im_wdata), e.imm);
                    end
                end
            end
        end
    end

    task automatic drive_req(input logic [1:0] f, input logic [6:0] op,
                             input logic [4:0] rd_i, input logic [4:0] rs1_i,
                             input logic [4:0] rs2_i, input logic [2:0] f3_i,
                             input logic [31:0] imm_i, output bit ok);
        @(negedge clk);
        fmt = f; opcode = op; rd = rd_i; rs1 = rs1_i;
        rs2 = rs2_i; funct3 = f3_i; imm = imm_i;
        in_valid = 1'b1;
        ok = 1'b0;
        for (int i = 0; i < 20; i++) begin
            if (in_ready) begin
                ok = 1'b1;
                break;
            end
            @(negedge clk);
        end
        if (!ok) begin
            checks++;
            errors++;
            $display("FAIL handshake_timeout got in_ready %b want 1", in_ready);
            in_valid = 1'b0;
            return;
        end
        @(posedge clk);
        #1 in_valid = 1'b0;
    endtask

    task automatic send(input logic [1:0] f, input logic [6:0] op,
                        input logic [4:0] rd_i, input logic [4:0] rs1_i,
                        input logic [4:0] rs2_i, input logic [2:0] f3_i,
                        input logic [31:0] imm_i, input logic exact,
                        input logic [31:0] data, input logic [1:0] code);
        bit ok;
        bit done;
        if (code == 2'd0) begin
            exp_t e;
            e.addr = m_addr; e.data = data; e.exact = exact;
            e.fmt = f; e.imm = imm_i; e.op = op;
            sb.push_back(e);
        end
        drive_req(f, op, rd_i, rs1_i, rs2_i, f3_i, imm_i, ok);
        if (!ok) return;
        done = 1'b0;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            if (in_ready || err) begin
                done = 1'b1;
                break;
            end
        end
        checks++;
        if (!done) begin
            errors++;
            $display("FAIL completion_timeout in_ready %b err %b", in_ready, err);
        end else if (code == 2'd0) begin
            if (err !== 1'b0) begin
                errors++;
                $display("FAIL unexpected_err got %b code %0d want 0",
                         err, err_code);
            end
            m_count++;
            if (&m_addr) m_full = 1'b1;
            else m_addr++;
        end else begin
            if (err !== 1'b1 || err_code !== code) begin
                errors++;
                $display("FAIL err_code got err %b code %0d want err 1 code %0d",
                         err, err_code, code);
            end
        end
    endtask

    task automatic send_rand(input logic [1:0] code);
        logic [31:0] r;
        logic [31:0] v;
        logic [1:0]  f;
        r = $urandom;
        f = 2'($urandom_range(0, 3));
        case (f)
            2'd0, 2'd1: v = {{20{r[11]}}, r[11:0]};
            2'd2:       v = {{19{r[12]}}, r[12:1], 1'b0};
            default:    v = {{11{r[20]}}, r[20:1], 1'b0};
        endcase
        send(f, 7'($urandom_range(0, 127)), 5'($urandom_range(0, 31)),
             5'($urandom_range(0, 31)), 5'($urandom_range(0, 31)),
             3'($urandom_range(0, 7)), v, 1'b0, 32'h0, code);
    endtask

    task automatic do_start(input logic with_valid);
        @(negedge clk);
        start = 1'b1;
        in_valid = with_valid;
        #1;
        checks++;
        if (in_ready !== 1'b0) begin
            errors++;
            $display("FAIL start_ready got %b want 0", in_ready);
        end
        @(posedge clk);
        #1 start = 1'b0;
        in_valid = 1'b0;
        m_addr = '0; m_full = 1'b0; m_count = '0;
    endtask

    task automatic clear_err();
        @(negedge clk);
        clr_err = 1'b1;
        @(posedge clk);
        #1 clr_err = 1'b0;
    endtask

    task automatic test_reset();
        #12;
        checks++;
        if (in_ready !== 1'b1 || im_we !== 1'b0 || im_addr !== '0 ||
            im_wdata !== 32'h0 || err !== 1'b0 || err_code !== 2'd0 ||
            full !== 1'b0 || count !== '0) begin
            errors++;
            $display("FAIL reset_state got rdy %b we %b a %h d %h e %b c %0d f %b n %0d want 1 0 0 0 0 0 0 0",
                     in_ready, im_we, im_addr, im_wdata, err, err_code, full, count);
        end
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    task automatic test_i_type();
        bit ok;
        exp_t e;
        e.addr = '0; e.data = 32'h00500093; e.exact = 1'b1;
        e.fmt = 2'd0; e.imm = 32'd5; e.op = 7'h13;
        sb.push_back(e);
        drive_req(2'd0, 7'h13, 5'd1, 5'd0, 5'd0, 3'd0, 32'd5, ok);
        @(negedge clk);
        checks++;
        if (im_we !== 1'b0) begin
            errors++;
            $display("FAIL addi_we_enc got %b want 0", im_we);
        end
        @(negedge clk);
        checks++;
        if (im_we !== 1'b1) begin
            errors++;
            $display("FAIL addi_we_wr got %b want 1", im_we);
        end
        @(negedge clk);
        checks++;
        if (im_we !== 1'b0 || count !== 3'd1 || im_addr !== 2'd1) begin
            errors++;
            $display("FAIL addi_after got we %b count %0d addr %0d want 0 1 1",
                     im_we, count, im_addr);
        end
        m_count = 3'd1;
        m_addr = 2'd1;
    endtask

    task automatic test_s_b();
        do_start(1'b0);
        send(2'd1, 7'h23, 5'd0, 5'd1, 5'd2, 3'd2, 32'd8,
             1'b1, 32'h0020A423, 2'd0);
        send(2'd2, 7'h63, 5'd0, 5'd0, 5'd0, 3'd0, 32'hFFFFFFFC,
             1'b1, 32'hFE000EE3, 2'd0);
    endtask

    task automatic test_jal();
        do_start(1'b0);
        send(2'd3, 7'h6F, 5'd1, 5'd0, 5'd0, 3'd0, 32'h800,
             1'b1, 32'h001000EF, 2'd0);
    endtask

    task automatic test_errors();
        send(2'd0, 7'h13, 5'd1, 5'd0, 5'd0, 3'd0, 32'd2048,
             1'b0, 32'h0, 2'd1);
        @(negedge clk);
        checks++;
        if (in_ready !== 1'b0 || err !== 1'b1) begin
            errors++;
            $display("FAIL err_hold got rdy %b err %b want 0 1", in_ready, err);
        end
        clear_err();
        @(negedge clk);
        checks++;
        if (err !== 1'b0 || err_code !== 2'd0 || in_ready !== 1'b1 ||
            im_addr !== m_addr || count !== m_count) begin
            errors++;
            $display("FAIL clr_err got e %b c %0d rdy %b a %0d n %0d want 0 0 1 %0d %0d",
                     err, err_code, in_ready, im_addr, count, m_addr, m_count);
        end
        send(2'd2, 7'h63, 5'd0, 5'd0, 5'd0, 3'd0, 32'd3,
             1'b0, 32'h0, 2'd2);
        clear_err();
    endtask

    task automatic test_full();
        do_start(1'b0);
        for (int i = 0; i < 4; i++) send_rand(2'd0);
        checks++;
        if (full !== 1'b1 || im_addr !== 2'd3 || count !== 3'd4) begin
            errors++;
            $display("FAIL full_set got f %b a %0d n %0d want 1 3 4",
                     full, im_addr, count);
        end
        send_rand(2'd3);
        clear_err();
        @(negedge clk);
        checks++;
        if (full !== 1'b1 || im_addr !== 2'd3 || count !== 3'd4) begin
            errors++;
            $display("FAIL full_keep got f %b a %0d n %0d want 1 3 4",
                     full, im_addr, count);
        end
        do_start(1'b1);
        @(negedge clk);
        checks++;
        if (full !== 1'b0 || im_addr !== 2'd0 || count !== 3'd0 ||
            in_ready !== 1'b1) begin
            errors++;
            $display("FAIL start_clr got f %b a %0d n %0d rdy %b want 0 0 0 1",
                     full, im_addr, count, in_ready);
        end
    endtask

    task automatic test_random();
        for (int k = 0; k < 8; k++) begin
            do_start(1'b0);
            for (int i = 0; i < 4; i++) send_rand(2'd0);
        end
    endtask

    task automatic test_reset_mid_wr();
        bit ok;
        do_start(1'b0);
        send_rand(2'd0);
        drive_req(2'd0, 7'h13, 5'd3, 5'd4, 5'd0, 3'd0, 32'd7, ok);
        @(posedge clk);
        #1;
        checks++;
        if (im_we !== 1'b1) begin
            errors++;
            $display("FAIL midwr_we_pre got %b want 1", im_we);
        end
        rst_n = 1'b0;
        #1;
        checks++;
        if (im_we !== 1'b0 || count !== '0 || in_ready !== 1'b1 ||
            im_addr !== '0 || full !== 1'b0) begin
            errors++;
            $display("FAIL midwr_reset got we %b n %0d rdy %b a %0d f %b want 0 0 1 0 0",
                     im_we, count, in_ready, im_addr, full);
        end
        @(negedge clk);
        rst_n = 1'b1;
        m_addr = '0; m_full = 1'b0; m_count = '0;
        repeat (3) @(negedge clk);
    endtask

    initial begin
        test_reset();
        test_i_type();
        test_s_b();
        test_jal();
        test_errors();
        test_full();
        test_random();
        test_reset_mid_wr();
        repeat (2) @(negedge clk);
        checks++;
        if (sb.size() != 0) begin
            errors++;
            $display("FAIL missing_writes got %0d pending want 0", sb.size());
        end
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/imm_instr_encoder.md
# imm_instr_encoder

Instruction encoder and instruction-memory loader for the single-cycle RISC-V core. It accepts decoded instruction fields plus a 32-bit signed immediate over a valid/ready handshake. It scatters the immediate into the I/S/B/J bit layout the core's immediate extender expects, range- and alignment-checks it, and writes the finished word into instruction memory at an auto-incrementing address. It is the inverse of the core's immediate extraction and is used by the test harness and boot path to build programs in hardware.

## Interface
- ADDR_W, 8, instruction-memory word-address width.
- BASE_ADDR, 0, word address loaded by reset and by `start`.

- clk  in  1  clock; all state changes on the rising edge.
- rst_n  in  1  asynchronous, active-low reset.
- start  in  1  pulse; restarts the address counter (honoured in IDLE only).
- clr_err  in  1  pulse; leaves ERR.
- in_valid  in  1  request valid.
- in_ready  out  1  `(state==IDLE) && !start`.
- fmt  in  2  format: 0=I, 1=S, 2=B, 3=J (same coding as the core's ImmSrc).
- opcode  in  7  opcode field.
- rd  in  5  destination register.
- rs1  in  5  source register 1.
- rs2  in  5  source register 2.
- funct3  in  3  funct3 field.
- imm  in  32  signed byte-offset/immediate.
- im_we  out  1  instruction-memory write strobe, one cycle.
- im_addr  out  ADDR_W  registered word-address counter.
- im_wdata  out  32  encoded instruction.
- err  out  1  sticky error, set in ERR.
- err_code  out  2  0=none, 1=range, 2=misaligned, 3=memory full.
- full  out  1  last address written; further writes refused.
- count  out  ADDR_W+1  words written since reset/start.

## Operation
FSM states: IDLE, ENC, WR, ERR.
- **IDLE:**
  - `start`=1 sets im_addr=BASE_ADDR, full=0, count=0; any request is not accepted.
  - Otherwise, on in_valid&&in_ready, fmt/opcode/rd/rs1/rs2/funct3/imm are registered and the FSM goes to ENC.
- **ENC:** encode and check, then register the result. Next state is WR if no error, else ERR with err_code latched.
- **WR:**
  - im_we=1, im_addr and im_wdata are stable.
  - At the edge: count+1.
  - If im_addr is all-ones, full=1 and im_addr holds; else im_addr+1.
  - Next state: IDLE.
- **ERR:**
  - err=1, in_ready=0, no write.
  - On clr_err: err=0, err_code=0, go to IDLE; im_addr, full and count are unchanged.

Encodings (fields unused by a format are ignored):
- I: {imm[11:0], rs1, funct3, rd, opcode}
- S: {imm[11:5], rs2, rs1, funct3, imm[4:0], opcode}
- B: {imm[12], imm[10:5], rs2, rs1, funct3, imm[4:1], imm[11], opcode}
- J: {imm[20], imm[10:1], imm[11], imm[19:12], rd, opcode}

Checks (priority full > misaligned > range):
- full=1 when accepted → code 3.
- B/J with imm[0]=1 → code 2.
- Range violations → code 1:
  - I/S: imm[31:11] not all equal.
  - B: imm[31:12] not all equal.
  - J: imm[31:20] not all equal.

Required property: sign-extending im_wdata with ImmSrc=fmt returns imm exactly for every legal input.

## Timing
- Request accepted at edge E0; im_we high during the cycle after E1; address advances at E2.
- Throughput: one word per 3 cycles. Errored requests reach ERR at E1.
- Reset values:
  - state: IDLE, so in_ready=1.
  - im_we=0, im_addr=BASE_ADDR, im_wdata=0.
  - err=0, err_code=0, full=0, count=0.
- rst_n low in any state: all of the above apply immediately. An in-flight request is discarded with no write, including mid-WR, where im_we drops asynchronously.
- `start` in ENC, WR or ERR is ignored. `start` together with in_valid in IDLE: start wins and in_ready=0 that cycle.
- `clr_err` outside ERR is ignored.
- The address counter never wraps.

## Test plan
- addi x1,x0,5 (fmt=0, opcode=0x13, rd=1, rs1=0, funct3=0, imm=5) → im_wdata=0x00500093 at addr 0, im_we high exactly one cycle, 2 cycles after accept; count=1.
- sw x2,8(x1) (fmt=1, opcode=0x23, rs1=1, rs2=2, funct3=2, imm=8), then beq x0,x0,-4 (fmt=2, opcode=0x63, imm=0xFFFFFFFC) → 0x0020A423 at addr 0, 0xFE000EE3 at addr 1.
- jal x1,2048 (fmt=3, opcode=0x6F, rd=1, imm=0x800) → 0x001000EF. Also run a randomized legal sweep: decoding every output with ImmSrc=fmt equals imm.
- Errors:
  - fmt=0, imm=2048 → ERR, err_code=1, no write.
  - clr_err, then fmt=2, imm=3 → err_code=2.
  - After clr_err, im_addr and count are unchanged.
- ADDR_W=2: four writes → addrs 0..3, full=1, im_addr=3; a fifth request → err_code=3. `start` with in_valid high → in_ready=0 that cycle, then im_addr=0, full=0, count=0.
- rst_n low during WR → im_we drops immediately, count=0, in_ready=1, im_addr=BASE_ADDR.
